// File: rtl/adam_pause_pkg.sv
// Shared types for the ordered pause/resume sequencer.
package adam_pause_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/adam_pause_sequencer_if.sv
// Upstream req/ack pause port plus the fanned-out per-endpoint req/ack pairs.
interface adam_pause_sequencer_if #(
    parameter int unsigned NO_MSTS = 8
);
    logic               slv_req;
    logic               slv_ack;
    logic [NO_MSTS-1:0] mst_req;
    logic [NO_MSTS-1:0] mst_ack;

    // Sequencer side: answers the upstream port, drives the endpoints.
    modport slave (
        input  slv_req,
        input  mst_ack,
        output slv_ack,
        output mst_req
    );

    // Environment side: upstream requester and downstream endpoints.
    modport master (
        output slv_req,
        output mst_ack,
        input  slv_ack,
        input  mst_req
    );
endinterface

// File: rtl/adam_pause_sequencer.sv
// Ordered pause/resume fan-out: resume walks endpoints upward, pause walks
// them downward, one endpoint at a time, with a per-endpoint ack watchdog.
module adam_pause_sequencer
    import adam_pause_pkg::*;
#(
    parameter int unsigned NO_MSTS = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    adam_pause_sequencer_if.slave  pif,
    input  logic [NO_MSTS-1:0]     en,
    output logic [NO_MSTS-1:0]     err,
    input  logic                   err_clr,
    output logic                   busy
);

    localparam int unsigned IW = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e             state;
    logic               tgt;
    logic [NO_MSTS-1:0] en_q;
    logic [IW-1:0]      idx;
    logic [TW-1:0]      timer;
    logic [NO_MSTS-1:0] mst_req_q;
    logic               slv_ack_q;
    logic [NO_MSTS-1:0] err_q;
    logic               busy_q;

    logic               skip;
    logic               ack_hit;
    logic               to_hit;
    logic               advance;
    logic               idx_last;
    logic [IW-1:0]      idx_next;

    // Last index in walk order: top index when resuming, zero when pausing.
    function automatic logic is_last(input logic [IW-1:0] i, input logic t);
        return t ? (i == '0) : (i == IW'(NO_MSTS - 1));
    endfunction

    function automatic logic [IW-1:0] step(input logic [IW-1:0] i, input logic t);
        return t ? (i - IW'(1)) : (i + IW'(1));
    endfunction

    always_comb begin
        skip     = !en_q[idx] || ((mst_req_q[idx] == tgt) && (pif.mst_ack[idx] == tgt));
        ack_hit  = (pif.mst_ack[idx] == tgt);
        to_hit   = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
        idx_last = is_last(idx, tgt);
        idx_next = step(idx, tgt);
        advance  = 1'b0;
        case (state)
            SCAN:    advance = skip;
            WAIT:    advance = ack_hit || to_hit;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tgt       <= 1'b1;
            en_q      <= '0;
            idx       <= '0;
            timer     <= '0;
            mst_req_q <= '1;
            slv_ack_q <= 1'b1;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            // A timeout set later in this block overrides the clear for its bit.
            if (err_clr) begin
                err_q <= '0;
            end
            case (state)
                IDLE: begin
                    if (pif.slv_req != slv_ack_q) begin
                        tgt    <= pif.slv_req;
                        en_q   <= en;
                        idx    <= pif.slv_req ? IW'(NO_MSTS - 1) : '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!skip) begin
                        mst_req_q[idx] <= tgt;
                        timer          <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (!ack_hit) begin
                        if (to_hit) begin
                            err_q[idx] <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                FINISH: begin
                    slv_ack_q <= tgt;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (advance) begin
                if (idx_last) begin
                    state <= FINISH;
                end else begin
                    idx   <= idx_next;
                    state <= SCAN;
                end
            end
        end
    end

    assign pif.mst_req = mst_req_q;
    assign pif.slv_ack = slv_ack_q;
    assign err         = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_adam_pause_sequencer.sv
// Directed bench for adam_pause_sequencer: one default-TIMEOUT instance and
// one TIMEOUT=16 instance for the watchdog scenario.
module tb_adam_pause_sequencer;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] en, en_to;
    logic [N-1:0] err, err_to;
    logic         err_clr, err_clr_to;
    logic         busy, busy_to;

    int           dly [N];
    int           cnt [N];
    logic [N-1:0] stuck_to;

    int n_cmp = 0;
    int n_err = 0;

    adam_pause_sequencer_if #(.NO_MSTS(N)) pif ();
    adam_pause_sequencer_if #(.NO_MSTS(N)) pif_to ();

    adam_pause_sequencer #(.NO_MSTS(N), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .pif(pif), .en(en), .err(err),
        .err_clr(err_clr), .busy(busy)
    );

    adam_pause_sequencer #(.NO_MSTS(N), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .pif(pif_to), .en(en_to), .err(err_to),
        .err_clr(err_clr_to), .busy(busy_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Endpoint model: ack follows req after dly[i] cycles (0 = same cycle).
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                pif.mst_ack[i] = pif.mst_req[i];
                cnt[i] = 0;
            end else if (pif.mst_ack[i] !== pif.mst_req[i]) begin
                if (cnt[i] >= dly[i]) begin
                    pif.mst_ack[i] = pif.mst_req[i];
                    cnt[i] = 0;
                end else begin
                    cnt[i] = cnt[i] + 1;
                end
            end else begin
                cnt[i] = 0;
            end
            if (rst || !stuck_to[i]) pif_to.mst_ack[i] = pif_to.mst_req[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pif.slv_req = 1'b1;
        pif_to.slv_req = 1'b1;
        en = '1;
        en_to = '1;
        err_clr = 1'b0;
        err_clr_to = 1'b0;
        stuck_to = '0;
        for (int i = 0; i < N; i++) dly[i] = 0;
        repeat (3) tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (pif.mst_req !== 8'hFF) begin
                n_err++; $display("FAIL reset_mst_req: got %h want ff", pif.mst_req);
            end
            n_cmp++;
            if (pif.slv_ack !== 1'b1) begin
                n_err++; $display("FAIL reset_slv_ack: got %b want 1", pif.slv_ack);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL reset_busy: got %b want 0", busy);
            end
            n_cmp++;
            if (err !== 8'h00) begin
                n_err++; $display("FAIL reset_err: got %h want 00", err);
            end
            n_cmp++;
            if (pif_to.mst_req !== 8'hFF) begin
                n_err++; $display("FAIL reset_to_mst_req: got %h want ff", pif_to.mst_req);
            end
            rst = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic test_resume();
        logic [N-1:0] prev;
        int           k;
        int           n;
        bit           done;
        prev = pif.mst_req;
        k = 0;
        done = 0;
        pif.slv_req = 1'b0;
        for (n = 1; n <= 100 && !done; n++) begin
            tick();
            if (n == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL resume_busy: got %b want 1", busy);
                end
            end
            if (pif.mst_req !== prev) begin
                n_cmp++;
                if (pif.mst_req !== (prev & ~(N'(1) << k)) || n != 2 + 2 * k) begin
                    n_err++;
                    $display("FAIL resume_order: got %h at n=%0d want %h at n=%0d",
                             pif.mst_req, n, prev & ~(N'(1) << k), 2 + 2 * k);
                end
                prev = pif.mst_req;
                k++;
            end
            if (pif.slv_ack === 1'b0) begin
                done = 1;
                n_cmp++;
                if (n != 18) begin
                    n_err++; $display("FAIL resume_latency: got %0d want 18", n);
                end
            end
        end
        n_cmp++;
        if (!done || pif.mst_req !== 8'h00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL resume_end: done=%0d mst_req=%h busy=%b want done=1 mst_req=00 busy=0",
                     done, pif.mst_req, busy);
        end
    endtask

    task automatic test_pause_delayed();
        int           table_d [N] = '{3, 0, 100, 17, 1, 55, 9, 40};
        logic [N-1:0] prev;
        logic [N-1:0] rose;
        logic [N-1:0] hi;
        int           exp_bit;
        bit           done;
        for (int i = 0; i < N; i++) dly[i] = table_d[i];
        prev = pif.mst_req;
        exp_bit = N - 1;
        done = 0;
        pif.slv_req = 1'b1;
        for (int n = 1; n <= 2000 && !done; n++) begin
            tick();
            rose = pif.mst_req & ~prev;
            if (rose != '0) begin
                hi = '1;
                hi = hi << (exp_bit + 1);
                n_cmp++;
                if (rose !== (N'(1) << exp_bit) || (pif.mst_ack & hi) !== hi) begin
                    n_err++;
                    $display("FAIL pause_order: rose=%h ack=%h want rose=%h with ack&%h set",
                             rose, pif.mst_ack, N'(1) << exp_bit, hi);
                end
                exp_bit--;
                prev = pif.mst_req;
            end
            if (pif.slv_ack === 1'b1) begin
                done = 1;
                n_cmp++;
                if (pif.mst_ack !== 8'hFF || pif.mst_req !== 8'hFF || exp_bit != -1) begin
                    n_err++;
                    $display("FAIL pause_ack: mst_ack=%h mst_req=%h left=%0d want ff ff -1",
                             pif.mst_ack, pif.mst_req, exp_bit);
                end
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL pause_timeout: slv_ack=%b want 1", pif.slv_ack);
        end
        for (int i = 0; i < N; i++) dly[i] = 0;
    endtask

    task automatic test_mask();
        bit done;
        done = 0;
        en = 8'hAA;
        pif.slv_req = 1'b0;
        for (int n = 1; n <= 100 && !done; n++) begin
            tick();
            if (n == 3) en = '1;
            if (pif.slv_ack === 1'b0) begin
                done = 1;
                n_cmp++;
                if (n != 14) begin
                    n_err++; $display("FAIL mask_latency: got %0d want 14", n);
                end
            end
        end
        n_cmp++;
        if (!done || pif.mst_req !== 8'h55) begin
            n_err++;
            $display("FAIL mask_result: done=%0d mst_req=%h want done=1 mst_req=55", done, pif.mst_req);
        end
    endtask

    task automatic test_timeout();
        bit done;
        done = 0;
        stuck_to = 8'h08;
        pif_to.slv_req = 1'b0;
        for (int n = 1; n <= 300 && !done; n++) begin
            tick();
            if (n == 23) begin
                n_cmp++;
                if (err_to !== 8'h00) begin
                    n_err++; $display("FAIL timeout_early: err=%h want 00 at n=23", err_to);
                end
            end
            if (n == 24) begin
                n_cmp++;
                if (err_to !== 8'h08) begin
                    n_err++; $display("FAIL timeout_set: err=%h want 08 at n=24", err_to);
                end
            end
            if (n == 25) begin
                n_cmp++;
                if (pif_to.mst_req !== 8'hE0) begin
                    n_err++; $display("FAIL timeout_continue: mst_req=%h want e0", pif_to.mst_req);
                end
            end
            if (pif_to.slv_ack === 1'b0) begin
                done = 1;
                n_cmp++;
                if (n != 33) begin
                    n_err++; $display("FAIL timeout_latency: got %0d want 33", n);
                end
            end
        end
        n_cmp++;
        if (!done || pif_to.mst_req !== 8'h00 || err_to !== 8'h08) begin
            n_err++;
            $display("FAIL timeout_end: done=%0d mst_req=%h err=%h want 1 00 08",
                     done, pif_to.mst_req, err_to);
        end
        err_clr_to = 1'b1;
        tick();
        err_clr_to = 1'b0;
        n_cmp++;
        if (err_to !== 8'h00) begin
            n_err++; $display("FAIL timeout_clear: err=%h want 00", err_to);
        end
        stuck_to = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] prev;
        bit           done;
        bit           first;
        done = 0;
        en = '1;
        pif.slv_req = 1'b1;
        for (int n = 1; n <= 500 && !done; n++) begin
            tick();
            if (pif.slv_ack === 1'b1) done = 1;
        end
        n_cmp++;
        if (!done || pif.mst_req !== 8'hFF) begin
            n_err++; $display("FAIL mid_prep: slv_ack=%b mst_req=%h want 1 ff", pif.slv_ack, pif.mst_req);
        end
        dly[2] = 50;
        pif.slv_req = 1'b0;
        done = 0;
        for (int n = 1; n <= 100 && !done; n++) begin
            tick();
            if (pif.mst_req === 8'hF8) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL mid_wait_idx2: mst_req=%h want f8", pif.mst_req);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (pif.mst_req !== 8'hFF || pif.slv_ack !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: mst_req=%h slv_ack=%b busy=%b want ff 1 0",
                     pif.mst_req, pif.slv_ack, busy);
        end
        rst = 1'b0;
        dly[2] = 0;
        prev = pif.mst_req;
        first = 1;
        done = 0;
        for (int n = 1; n <= 100 && !done; n++) begin
            tick();
            if (first && pif.mst_req !== prev) begin
                first = 0;
                n_cmp++;
                if (pif.mst_req !== 8'hFE || n != 2) begin
                    n_err++;
                    $display("FAIL mid_restart: mst_req=%h at n=%0d want fe at n=2", pif.mst_req, n);
                end
            end
            if (pif.slv_ack === 1'b0) begin
                done = 1;
                n_cmp++;
                if (n != 18 || pif.mst_req !== 8'h00) begin
                    n_err++;
                    $display("FAIL mid_resume: n=%0d mst_req=%h want 18 00", n, pif.mst_req);
                end
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL mid_resume_timeout: slv_ack=%b want 0", pif.slv_ack);
        end
    endtask

    initial begin
        test_reset();
        test_resume();
        test_pause_delayed();
        test_mask();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adam_pause_sequencer.md
Name: adam_pause_sequencer

Overview:
Ordered pause/resume controller for NO_MSTS downstream pause endpoints, using the req/ack level protocol: ack follows req.
- req=1 means pause; the endpoint is paused when ack=1.
- req=0 means resume; the endpoint is resumed when ack=0.
One upstream slave pause port is fanned out one endpoint at a time:
- Resume runs in ascending index order.
- Pause runs in descending index order.
This enforces dependency order between domains that a parallel demux cannot. A per-endpoint enable mask selects which endpoints take part, and a per-endpoint watchdog flags endpoints that never acknowledge.

Parameters:
NO_MSTS, 8, number of downstream endpoints (>=1)
TIMEOUT, 1024, max consecutive WAIT cycles before an endpoint is declared failed; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
slv_req  in  1  upstream pause request
slv_ack  out  1  upstream pause acknowledge
mst_req  out  NO_MSTS  per-endpoint pause request
mst_ack  in  NO_MSTS  per-endpoint pause acknowledge
en  in  NO_MSTS  per-endpoint participation mask; sampled at sequence start
err  out  NO_MSTS  sticky per-endpoint timeout flags
err_clr  in  1  clears all err bits
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: mst_req all 1, slv_ack=1, err=0, busy=0, state IDLE, idx=0, timer=0. The block comes out of reset fully paused.
- A reset mid-sequence aborts the sequence immediately with the same values. No partial state survives.
- Registers: tgt (1b), en_q (NO_MSTS), idx ($clog2(NO_MSTS), min 1 bit), timer ($clog2(TIMEOUT+1)).
- IDLE:
  - If slv_req != slv_ack: tgt<=slv_req, en_q<=en, idx<=(slv_req ? NO_MSTS-1 : 0), go SCAN.
  - Otherwise stay in IDLE.
- SCAN, skip case: if !en_q[idx], or (mst_req[idx]==tgt && mst_ack[idx]==tgt):
  - mst_req[idx] is left unchanged.
  - If idx is the last index in sequence order, go FINISH; otherwise step idx toward the end and stay in SCAN.
- SCAN, drive case (otherwise): mst_req[idx]<=tgt, timer<=0, go WAIT.
- WAIT:
  - If mst_ack[idx]==tgt: advance as in SCAN (step idx to SCAN, or go FINISH if last).
  - Else if TIMEOUT!=0 && timer==TIMEOUT-1: err[idx]<=1 and advance the same way. mst_req[idx] stays at tgt.
  - Else timer<=timer+1.
- FINISH: slv_ack<=tgt, go IDLE.
- Latency from the edge sampling the slv_req change to the edge setting slv_ack, with zero-delay acks: 2 + 2*(driven endpoints) + (skipped endpoints) cycles. Each extra ack-delay cycle adds 1.
- Protocol violation: slv_req toggling before slv_ack matches is ignored until the current sequence finishes. IDLE then sees the mismatch and starts a new sequence in the opposite direction. slv_ack never pulses to an intermediate value.
- Masked endpoints keep their previous mst_req indefinitely. After reset they therefore stay paused.
- Changes to en during a sequence have no effect, because en_q is latched.
- err_clr and an err set on the same cycle: the set wins for that bit; all other bits clear.
- mst_ack changes on endpoints other than idx are ignored.

Decomposition:
- Package adam_pause_pkg: state enum (IDLE, SCAN, WAIT, FINISH), 2-bit encoded.
- idx stepping and last-index detection go in a local function.
- No sub-module; timer and FSM are inline.

Test Plan:
1. Reset, slv_req=1, en=all 1 -> mst_req=8'hFF, slv_ack=1, busy=0, err=0 throughout.
2. Resume with zero-delay acks: after reset, slv_req 1->0 -> mst_req bits clear in order 0,1,...,7, one every 2 cycles. slv_ack falls exactly 18 cycles after slv_req is sampled.
3. Pause with random acks: drive slv_req 0->1 with mst_ack delays of 0-100 cycles -> mst_req bits set in order 7..0. No bit i-1 is set before mst_ack[i]=1. slv_ack=1 only after all mst_ack=1.
4. Mask: en=8'b1010_1010, resume -> only odd mst_req clear, even bits stay 1. slv_ack=0 after 2+8+4=14 cycles.
5. Timeout: TIMEOUT=16, mst_ack[3] stuck at 1 during resume -> err=8'h08 after 16 WAIT cycles, and the sequence continues to endpoint 4. Then err_clr=1 -> err=0.
6. Reset mid-sequence: rst during WAIT on idx 2 -> next cycle mst_req=8'hFF, slv_ack=1, busy=0. With slv_req still 0, a fresh resume starts from idx 0.
